// File: rtl/age_matrix_pkg.sv
// rtl/age_matrix_pkg.sv - shared constants and bit-vector helpers for the age-matrix issue queue
// Purpose: default entry count plus popcount/onehot helpers used by the select and
//          assertion logic. Callers zero-extend their vectors to PopMaxW bits.
// Ports:   none (package)
package age_matrix_pkg;

    localparam int DefaultEntryCount = 8;
    localparam int PopMaxW           = 64;

    function automatic int unsigned popcount(input logic [PopMaxW-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < PopMaxW; i++) begin
            if (v[i]) n++;
        end
        return n;
    endfunction

    function automatic logic onehot(input logic [PopMaxW-1:0] v);
        return popcount(v) == 1;
    endfunction

endpackage

// File: rtl/age_matrix_issue_queue_ctrl_if.sv
// rtl/age_matrix_issue_queue_ctrl_if.sv - enqueue/dequeue/flush/select bundle of the age-matrix controller
// Purpose: groups every non-clock signal of the controller.
// Ports (master drives the *_i signals, slave drives the *_o signals):
//   enq_fire_i/enq_mask_i  enqueue valid and one-hot target entry per port
//   deq_fire_i/deq_mask_i  dequeue valid and one-hot entry per port
//   flush_i/flush_mask_i   kill request and the entries it kills
//   sel_req_i              entries ready to be picked
//   result_mask_o/vld_o    oldest-first picks, slot 0 oldest
//   entry_vld_o, occupancy_o, full_o, empty_o  registered status
interface age_matrix_issue_queue_ctrl_if
    import age_matrix_pkg::*;
#(
    parameter int EntryCount = DefaultEntryCount,
    parameter int EnqWidth   = 2,
    parameter int DeqWidth   = 2,
    parameter int SelWidth   = 2
);
    localparam int CntWidth = $clog2(EntryCount + 1);

    logic [EnqWidth-1:0]                 enq_fire_i;
    logic [EnqWidth-1:0][EntryCount-1:0] enq_mask_i;
    logic [DeqWidth-1:0]                 deq_fire_i;
    logic [DeqWidth-1:0][EntryCount-1:0] deq_mask_i;
    logic                                flush_i;
    logic [EntryCount-1:0]               flush_mask_i;
    logic [EntryCount-1:0]               sel_req_i;
    logic [SelWidth-1:0][EntryCount-1:0] result_mask_o;
    logic [SelWidth-1:0]                 result_vld_o;
    logic [EntryCount-1:0]               entry_vld_o;
    logic [CntWidth-1:0]                 occupancy_o;
    logic                                full_o;
    logic                                empty_o;

    modport master (
        output enq_fire_i, enq_mask_i, deq_fire_i, deq_mask_i,
               flush_i, flush_mask_i, sel_req_i,
        input  result_mask_o, result_vld_o, entry_vld_o, occupancy_o, full_o, empty_o
    );

    modport slave (
        input  enq_fire_i, enq_mask_i, deq_fire_i, deq_mask_i,
               flush_i, flush_mask_i, sel_req_i,
        output result_mask_o, result_vld_o, entry_vld_o, occupancy_o, full_o, empty_o
    );

endinterface

// File: rtl/age_matrix_pick.sv
// rtl/age_matrix_pick.sv - one oldest-first select slot of the age matrix
// Purpose: picks the candidate that has no older candidate and removes it from
//          the candidate set for the next slot.
// Ports:
//   i_cand      candidate entries for this slot
//   i_age       age matrix, i_age[r][c]=1 means entry c is older than entry r
//   o_win       one-hot winner (zero if no candidate)
//   o_cand_nxt  candidates left for the next slot
module age_matrix_pick
    import age_matrix_pkg::*;
#(
    parameter int EntryCount = DefaultEntryCount
) (
    input  logic [EntryCount-1:0]                 i_cand,
    input  logic [EntryCount-1:0][EntryCount-1:0] i_age,
    output logic [EntryCount-1:0]                 o_win,
    output logic [EntryCount-1:0]                 o_cand_nxt
);

    logic [EntryCount-1:0] w_blocked;

    // The diagonal is skipped: an entry never blocks itself.
    always_comb begin
        for (int r = 0; r < EntryCount; r++) begin
            w_blocked[r] = 1'b0;
            for (int c = 0; c < EntryCount; c++) begin
                if (c != r && i_cand[c] && i_age[r][c]) w_blocked[r] = 1'b1;
            end
        end
    end

    assign o_win      = i_cand & ~w_blocked;
    assign o_cand_nxt = i_cand & ~o_win;

endmodule

// File: rtl/mux_oh.sv
// rtl/mux_oh.sv - one-hot select mux (OR of data words whose select bit is set)
// Purpose: generic one-hot mux; an all-zero select yields zero.
// Ports:
//   i_sel   N select bits, expected one-hot or zero
//   i_data  N data words of W bits
//   o_data  selected word
module MuxOH #(
    parameter int N = 2,
    parameter int W = 8
) (
    input  logic [N-1:0]        i_sel,
    input  logic [N-1:0][W-1:0] i_data,
    output logic [W-1:0]        o_data
);

    always_comb begin
        o_data = '0;
        for (int i = 0; i < N; i++) begin
            if (i_sel[i]) o_data |= i_data[i];
        end
    end

endmodule

// File: rtl/age_matrix_issue_queue_ctrl.sv
// rtl/age_matrix_issue_queue_ctrl.sv - age-ordered entry tracker with multi-port enq/deq/flush and oldest-first select
// Purpose: owns the entry valid vector, a registered age matrix and an occupancy
//          counter; the select path is combinational from registered state only.
// Ports:
//   clk  clock
//   rst  asynchronous active-high reset
//   bus  age_matrix_issue_queue_ctrl_if.slave (enq/deq/flush/select/status)
module age_matrix_issue_queue_ctrl
    import age_matrix_pkg::*;
#(
    parameter int EntryCount = DefaultEntryCount,
    parameter int EnqWidth   = 2,
    parameter int DeqWidth   = 2,
    parameter int SelWidth   = 2
) (
    input  logic clk,
    input  logic rst,
    age_matrix_issue_queue_ctrl_if.slave bus
);

    localparam int CntWidth = $clog2(EntryCount + 1);

    logic [EntryCount-1:0]                 r_vld;
    logic [EntryCount-1:0][EntryCount-1:0] r_age;
    logic [CntWidth-1:0]                   r_occ;
    logic                                  r_full;
    logic                                  r_empty;

    logic [EntryCount-1:0]                 w_enq_all;
    logic [EntryCount-1:0]                 w_deq_all;
    logic [EntryCount-1:0]                 w_flush_kill;
    logic [EntryCount-1:0]                 w_base;
    logic [EntryCount-1:0]                 w_vld_d;
    logic [EnqWidth-1:0][EntryCount-1:0]   w_enq_prefix;
    logic [EntryCount-1:0][EnqWidth-1:0]   w_enq_hit;
    logic [EntryCount-1:0][EntryCount-1:0] w_dep;
    logic [EntryCount-1:0][EntryCount-1:0] w_age_d;
    logic [CntWidth-1:0]                   w_occ_d;
    int unsigned                           w_enq_cnt;
    int unsigned                           w_clr_cnt;

    logic [SelWidth:0][EntryCount-1:0]     w_cand;
    logic [SelWidth-1:0][EntryCount-1:0]   w_win;

    // Fired-port masks, surviving entries and the next valid vector.
    always_comb begin
        w_enq_all = '0;
        w_deq_all = '0;
        for (int j = 0; j < EnqWidth; j++) begin
            if (bus.enq_fire_i[j]) w_enq_all |= bus.enq_mask_i[j];
        end
        for (int j = 0; j < DeqWidth; j++) begin
            if (bus.deq_fire_i[j]) w_deq_all |= bus.deq_mask_i[j];
        end
        w_flush_kill = bus.flush_i ? bus.flush_mask_i : '0;
        w_base       = r_vld & ~w_deq_all & ~w_flush_kill;
        w_vld_d      = w_base | w_enq_all;
    end

    // w_enq_prefix[j] = entries enqueued this cycle on lower (older) ports than j.
    always_comb begin
        w_enq_prefix = '0;
        for (int j = 1; j < EnqWidth; j++) begin
            w_enq_prefix[j] = w_enq_prefix[j-1]
                            | (bus.enq_fire_i[j-1] ? bus.enq_mask_i[j-1] : '0);
        end
    end

    always_comb begin
        for (int r = 0; r < EntryCount; r++) begin
            for (int j = 0; j < EnqWidth; j++) begin
                w_enq_hit[r][j] = bus.enq_fire_i[j] & bus.enq_mask_i[j][r];
            end
        end
    end

    // Per row: which lower-port enqueues the entry must treat as older.
    for (genvar r = 0; r < EntryCount; r++) begin : g_dep
        MuxOH #(
            .N (EnqWidth),
            .W (EntryCount)
        ) u_dep_mux (
            .i_sel  (w_enq_hit[r]),
            .i_data (w_enq_prefix),
            .o_data (w_dep[r])
        );
    end

    // An enqueued row is rewritten outright, which wins over the column clear
    // that every other enqueue in the same cycle applies to it. Rows of
    // dequeued/flushed entries stay stale; they are masked by r_vld on read.
    always_comb begin
        w_age_d = r_age;
        for (int r = 0; r < EntryCount; r++) begin
            for (int c = 0; c < EntryCount; c++) begin
                if (c == r) begin
                    w_age_d[r][c] = 1'b0;
                end else if (|w_enq_hit[r]) begin
                    w_age_d[r][c] = w_base[c] | w_dep[r][c];
                end else if (w_enq_all[c]) begin
                    w_age_d[r][c] = 1'b0;
                end
            end
        end
    end

    // Entries hit by both deq and flush are counted once via the OR.
    always_comb begin
        w_enq_cnt = popcount(PopMaxW'(w_enq_all));
        w_clr_cnt = popcount(PopMaxW'(r_vld & (w_deq_all | w_flush_kill)));
        w_occ_d   = r_occ + CntWidth'(w_enq_cnt) - CntWidth'(w_clr_cnt);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld   <= '0;
            r_age   <= '0;
            r_occ   <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            r_vld   <= w_vld_d;
            r_age   <= w_age_d;
            r_occ   <= w_occ_d;
            r_full  <= (w_occ_d == CntWidth'(EntryCount));
            r_empty <= (w_occ_d == '0);
        end
    end

    // Select chain: each slot removes its winner before the next looks.
    assign w_cand[0] = bus.sel_req_i & r_vld;

    for (genvar k = 0; k < SelWidth; k++) begin : g_sel
        age_matrix_pick #(
            .EntryCount (EntryCount)
        ) u_pick (
            .i_cand     (w_cand[k]),
            .i_age      (r_age),
            .o_win      (w_win[k]),
            .o_cand_nxt (w_cand[k+1])
        );
        assign bus.result_vld_o[k] = |w_win[k];
    end

    assign bus.result_mask_o = w_win;
    assign bus.entry_vld_o   = r_vld;
    assign bus.occupancy_o   = r_occ;
    assign bus.full_o        = r_full;
    assign bus.empty_o       = r_empty;

`ifndef SYNTHESIS
    a_enq_to_valid: assert property (@(posedge clk) disable iff (rst)
        (w_enq_all & r_vld) == '0);

    a_enq_room: assert property (@(posedge clk) disable iff (rst)
        popcount(PopMaxW'(bus.enq_fire_i)) + 32'(r_occ) <= 32'(EntryCount));

    a_pick_count: assert property (@(posedge clk) disable iff (rst)
        popcount(PopMaxW'(w_cand[0])) ==
        popcount(PopMaxW'(w_cand[SelWidth])) + popcount(PopMaxW'(bus.result_vld_o)));

    for (genvar j = 0; j < EnqWidth; j++) begin : g_enq_chk
        a_enq_onehot: assert property (@(posedge clk) disable iff (rst)
            bus.enq_fire_i[j] |-> onehot(PopMaxW'(bus.enq_mask_i[j])));
        for (genvar i = 0; i < j; i++) begin : g_pair
            a_enq_collide: assert property (@(posedge clk) disable iff (rst)
                !(bus.enq_fire_i[i] && bus.enq_fire_i[j]
                  && ((bus.enq_mask_i[i] & bus.enq_mask_i[j]) != '0)));
        end
    end

    for (genvar j = 0; j < DeqWidth; j++) begin : g_deq_chk
        a_deq_onehot: assert property (@(posedge clk) disable iff (rst)
            bus.deq_fire_i[j] |-> onehot(PopMaxW'(bus.deq_mask_i[j])));
        a_deq_valid: assert property (@(posedge clk) disable iff (rst)
            bus.deq_fire_i[j] |-> ((bus.deq_mask_i[j] & ~r_vld) == '0));
    end
`endif

endmodule

// File: tb/tb_age_matrix_issue_queue_ctrl.sv
// tb/tb_age_matrix_issue_queue_ctrl.sv - directed vector bench for the age-matrix issue queue controller
module tb_age_matrix_issue_queue_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    age_matrix_issue_queue_ctrl_if #(
        .EntryCount (8), .EnqWidth (2), .DeqWidth (2), .SelWidth (2)
    ) bus ();

    age_matrix_issue_queue_ctrl #(
        .EntryCount (8), .EnqWidth (2), .DeqWidth (2), .SelWidth (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // One record = one clock: x0/x1/xv are the picks before the edge,
    // xvld/xocc/xfull/xempty the registered state after it.
    typedef struct {
        logic [1:0]  ef;
        logic [15:0] em;
        logic [1:0]  df;
        logic [15:0] dm;
        logic        fl;
        logic [7:0]  fm;
        logic [7:0]  sr;
        logic [7:0]  x0;
        logic [7:0]  x1;
        logic [1:0]  xv;
        logic [7:0]  xvld;
        logic [3:0]  xocc;
        logic        xfull;
        logic        xempty;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic [1:0] ef, logic [15:0] em, logic [1:0] df, logic [15:0] dm,
                                logic fl, logic [7:0] fm, logic [7:0] sr,
                                logic [7:0] x0, logic [7:0] x1, logic [1:0] xv,
                                logic [7:0] xvld, logic [3:0] xocc, logic xfull, logic xempty);
        vec_t v;
        v.ef = ef; v.em = em; v.df = df; v.dm = dm; v.fl = fl; v.fm = fm; v.sr = sr;
        v.x0 = x0; v.x1 = x1; v.xv = xv; v.xvld = xvld; v.xocc = xocc;
        v.xfull = xfull; v.xempty = xempty;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.enq_fire_i   = v.ef;
        bus.enq_mask_i   = v.em;
        bus.deq_fire_i   = v.df;
        bus.deq_mask_i   = v.dm;
        bus.flush_i      = v.fl;
        bus.flush_mask_i = v.fm;
        bus.sel_req_i    = v.sr;
    endtask

    task automatic chk_pick(input string tag, input logic [7:0] x0, input logic [7:0] x1,
                            input logic [1:0] xv);
        chk({tag, " slot0"}, 32'(bus.result_mask_o[0]), 32'(x0));
        chk({tag, " slot1"}, 32'(bus.result_mask_o[1]), 32'(x1));
        chk({tag, " rvld"},  32'(bus.result_vld_o),     32'(xv));
    endtask

    task automatic chk_state(input string tag, input logic [7:0] xvld, input logic [3:0] xocc,
                             input logic xfull, input logic xempty);
        chk({tag, " vld"},   32'(bus.entry_vld_o), 32'(xvld));
        chk({tag, " occ"},   32'(bus.occupancy_o), 32'(xocc));
        chk({tag, " full"},  32'(bus.full_o),      32'(xfull));
        chk({tag, " empty"}, 32'(bus.empty_o),     32'(xempty));
    endtask

    initial begin
        // enqueue order 3,5,1 then 4; then 6 (port0) and 2 (port1) together
        tbl.push_back(mk(2'b01, 16'h0008, 2'b00, 16'h0000, 0, 8'h00, 8'hFF, 8'h00, 8'h00, 2'b00, 8'h08, 1, 0, 0));
        tbl.push_back(mk(2'b01, 16'h0020, 2'b00, 16'h0000, 0, 8'h00, 8'hFF, 8'h08, 8'h00, 2'b01, 8'h28, 2, 0, 0));
        tbl.push_back(mk(2'b01, 16'h0002, 2'b00, 16'h0000, 0, 8'h00, 8'hFF, 8'h08, 8'h20, 2'b11, 8'h2A, 3, 0, 0));
        tbl.push_back(mk(2'b00, 16'h0000, 2'b00, 16'h0000, 0, 8'h00, 8'hFF, 8'h08, 8'h20, 2'b11, 8'h2A, 3, 0, 0));
        tbl.push_back(mk(2'b01, 16'h0010, 2'b00, 16'h0000, 0, 8'h00, 8'hFF, 8'h08, 8'h20, 2'b11, 8'h3A, 4, 0, 0));
        tbl.push_back(mk(2'b11, 16'h0440, 2'b00, 16'h0000, 0, 8'h00, 8'h54, 8'h10, 8'h00, 2'b01, 8'h7E, 6, 0, 0));
        tbl.push_back(mk(2'b00, 16'h0000, 2'b00, 16'h0000, 0, 8'h00, 8'h54, 8'h10, 8'h40, 2'b11, 8'h7E, 6, 0, 0));
        tbl.push_back(mk(2'b00, 16'h0000, 2'b00, 16'h0000, 0, 8'h00, 8'h44, 8'h40, 8'h04, 2'b11, 8'h7E, 6, 0, 0));
        // oldest masked out, single candidate
        tbl.push_back(mk(2'b00, 16'h0000, 2'b00, 16'h0000, 0, 8'h00, 8'h02, 8'h02, 8'h00, 2'b01, 8'h7E, 6, 0, 0));
        // flush all together with deq of entry 3 (counted once)
        tbl.push_back(mk(2'b00, 16'h0000, 2'b01, 16'h0008, 1, 8'hFF, 8'hFF, 8'h08, 8'h20, 2'b11, 8'h00, 0, 0, 1));
        // fill 0..7 in order, two per cycle
        tbl.push_back(mk(2'b11, 16'h0201, 2'b00, 16'h0000, 0, 8'h00, 8'hFF, 8'h00, 8'h00, 2'b00, 8'h03, 2, 0, 0));
        tbl.push_back(mk(2'b11, 16'h0804, 2'b00, 16'h0000, 0, 8'h00, 8'hFF, 8'h01, 8'h02, 2'b11, 8'h0F, 4, 0, 0));
        tbl.push_back(mk(2'b11, 16'h2010, 2'b00, 16'h0000, 0, 8'h00, 8'hFF, 8'h01, 8'h02, 2'b11, 8'h3F, 6, 0, 0));
        tbl.push_back(mk(2'b11, 16'h8040, 2'b00, 16'h0000, 0, 8'h00, 8'hFC, 8'h04, 8'h08, 2'b11, 8'hFF, 8, 1, 0));
        // deq 0 and 1 on both ports, then re-enqueue 0 as youngest
        tbl.push_back(mk(2'b00, 16'h0000, 2'b11, 16'h0201, 0, 8'h00, 8'hC0, 8'h40, 8'h80, 2'b11, 8'hFC, 6, 0, 0));
        tbl.push_back(mk(2'b01, 16'h0001, 2'b00, 16'h0000, 0, 8'h00, 8'hFF, 8'h04, 8'h08, 2'b11, 8'hFD, 7, 0, 0));
        tbl.push_back(mk(2'b00, 16'h0000, 2'b00, 16'h0000, 0, 8'h00, 8'h81, 8'h80, 8'h01, 2'b11, 8'hFD, 7, 0, 0));
        tbl.push_back(mk(2'b00, 16'h0000, 2'b00, 16'h0000, 0, 8'h00, 8'hFF, 8'h04, 8'h08, 2'b11, 8'hFD, 7, 0, 0));
        tbl.push_back(mk(2'b01, 16'h0002, 2'b00, 16'h0000, 0, 8'h00, 8'h03, 8'h01, 8'h00, 2'b01, 8'hFF, 8, 1, 0));
        // flush F0 with deq of entry 4
        tbl.push_back(mk(2'b00, 16'h0000, 2'b01, 16'h0010, 1, 8'hF0, 8'hF0, 8'h10, 8'h20, 2'b11, 8'h0F, 4, 0, 0));
        tbl.push_back(mk(2'b00, 16'h0000, 2'b00, 16'h0000, 0, 8'h00, 8'h0F, 8'h04, 8'h08, 2'b11, 8'h0F, 4, 0, 0));
        // re-enqueue 6 over stale matrix bits: must be younger than 0
        tbl.push_back(mk(2'b01, 16'h0040, 2'b00, 16'h0000, 0, 8'h00, 8'h43, 8'h01, 8'h02, 2'b11, 8'h4F, 5, 0, 0));
        tbl.push_back(mk(2'b00, 16'h0000, 2'b00, 16'h0000, 0, 8'h00, 8'h41, 8'h01, 8'h40, 2'b11, 8'h4F, 5, 0, 0));

        drive(mk(0, 0, 0, 0, 0, 0, 8'hFF, 0, 0, 0, 0, 0, 0, 0));
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk_state("reset", 8'h00, 4'd0, 1'b0, 1'b1);
        chk_pick("reset", 8'h00, 8'h00, 2'b00);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i]);
            #1;
            chk_pick($sformatf("vec%0d", i), tbl[i].x0, tbl[i].x1, tbl[i].xv);
            @(posedge clk);
            #1;
            chk_state($sformatf("vec%0d", i), tbl[i].xvld, tbl[i].xocc, tbl[i].xfull, tbl[i].xempty);
            @(negedge clk);
        end

        // asynchronous reset mid-stream with five valid entries
        drive(mk(0, 0, 0, 0, 0, 0, 8'hFF, 0, 0, 0, 0, 0, 0, 0));
        #2;
        rst = 1'b1;
        #1;
        chk_state("async_rst", 8'h00, 4'd0, 1'b0, 1'b1);
        chk_pick("async_rst", 8'h00, 8'h00, 2'b00);
        @(negedge clk);
        rst = 1'b0;

        drive(mk(2'b01, 16'h0080, 0, 0, 0, 0, 8'hFF, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        @(negedge clk);
        drive(mk(0, 0, 0, 0, 0, 0, 8'hFF, 0, 0, 0, 0, 0, 0, 0));
        #1;
        chk_pick("post_rst", 8'h80, 8'h00, 2'b01);
        chk_state("post_rst", 8'h80, 4'd1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
